// File: rtl/mcu_spi_pkg.sv
// Shared constants for the MCU SPI slave: byte width, bit counter width and error-counter ceiling.
// Optional framing-error counter is enabled with MCU_SPI_FRAME_ERR_EN.
package mcu_spi_pkg;

    localparam int            MCU_SPI_BITS  = 8;
    localparam int            MCU_SPI_CNT_W = 3;
    localparam logic [7:0]    FRAME_ERR_MAX = 8'hFF;

    // Saturating increment used by the framing-error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        return (val == FRAME_ERR_MAX) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/mcu_spi_if.sv
// Pin and decoder-side signals of the MCU SPI slave.
// slave = the SPI block, master = MCU pins plus command decoder.
interface mcu_spi_if;
    import mcu_spi_pkg::*;

    logic                    spi_csn;
    logic                    spi_sclk;
    logic                    spi_mosi;
    logic                    spi_miso;
    logic [MCU_SPI_BITS-1:0] rx_data;
    logic                    rx_strobe;
    logic                    rx_start;
    logic [MCU_SPI_BITS-1:0] tx_data;

    modport slave (
        input  spi_csn, spi_sclk, spi_mosi, tx_data,
        output spi_miso, rx_data, rx_strobe, rx_start
    );

    modport master (
        output spi_csn, spi_sclk, spi_mosi, tx_data,
        input  spi_miso, rx_data, rx_strobe, rx_start
    );

endinterface

// File: rtl/mcu_spi_sync.sv
// STAGES-deep flop chain bringing one asynchronous SPI pin into the core clock domain.
// RST_VAL lets each pin reset to its idle level.
module mcu_spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/mcu_spi.sv
// SPI mode-0 slave: oversampled MOSI deserializer with byte strobes and MISO reply serializer.
// Define MCU_SPI_FRAME_ERR_EN to add the saturating frame_err_cnt output.
module mcu_spi
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    mcu_spi_if.slave        bus
`ifdef MCU_SPI_FRAME_ERR_EN
    ,
    output logic [7:0]      frame_err_cnt
`endif
);

    logic                     w_csn, w_sclk, w_mosi;
    logic                     w_rst_n, w_sclk_rise, w_sclk_fall, w_csn_fall;
    logic [SYNC_STAGES:0]     r_rst_sync;
    logic                     r_csn_d, r_sclk_d;
    logic                     r_armed, r_first, r_load, r_miso;
    logic                     r_rx_strobe, r_rx_start;
    logic [MCU_SPI_CNT_W-1:0] r_bit_cnt;
    logic [MCU_SPI_BITS-1:0]  r_rx_shift, r_rx_data, r_tx_shift;
`ifdef MCU_SPI_FRAME_ERR_EN
    logic [7:0]               r_frame_err_cnt;
`endif

    mcu_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk(clk), .reset_n(reset_n), .i_d(bus.spi_csn), .o_q(w_csn));
    mcu_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .i_d(bus.spi_sclk), .o_q(w_sclk));
    mcu_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .i_d(bus.spi_mosi), .o_q(w_mosi));

    // One stage deeper than the pin synchronizers, so the chains have flushed their
    // reset values before the core can arm on a stale "CSn high".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_rst_n     = r_rst_sync[SYNC_STAGES];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_csn_fall  = ~w_csn & r_csn_d;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_csn_d     <= 1'b1;
            r_sclk_d    <= 1'b0;
            r_armed     <= 1'b0;
            r_first     <= 1'b1;
            r_load      <= 1'b0;
            r_miso      <= 1'b0;
            r_rx_strobe <= 1'b0;
            r_rx_start  <= 1'b0;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_tx_shift  <= '0;
`ifdef MCU_SPI_FRAME_ERR_EN
            r_frame_err_cnt <= '0;
`endif
        end else begin
            r_csn_d     <= w_csn;
            r_sclk_d    <= w_sclk;
            r_rx_strobe <= 1'b0;
            r_rx_start  <= 1'b0;
            r_load      <= 1'b0;
            if (w_csn) begin
                r_armed   <= 1'b1;
                r_bit_cnt <= '0;
                r_first   <= 1'b1;
                r_miso    <= 1'b0;
`ifdef MCU_SPI_FRAME_ERR_EN
                if (r_bit_cnt != '0) begin
                    r_frame_err_cnt <= sat_inc(r_frame_err_cnt);
                end
`endif
            end else if (r_armed) begin
                r_load <= r_rx_strobe;
                if (w_csn_fall) begin
                    r_tx_shift <= bus.tx_data;
                    r_miso     <= bus.tx_data[MCU_SPI_BITS-1];
                end else begin
                    // Falling edge after the 8th rise (bit_cnt==0) must not disturb the reply MSB.
                    if (r_load) begin
                        r_tx_shift <= bus.tx_data;
                        r_miso     <= bus.tx_data[MCU_SPI_BITS-1];
                    end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                        r_tx_shift <= r_tx_shift << 1;
                        r_miso     <= r_tx_shift[MCU_SPI_BITS-2];
                    end
                    if (w_sclk_rise) begin
                        r_rx_shift <= {r_rx_shift[MCU_SPI_BITS-2:0], w_mosi};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == {MCU_SPI_CNT_W{1'b1}}) begin
                            r_rx_data   <= {r_rx_shift[MCU_SPI_BITS-2:0], w_mosi};
                            r_rx_strobe <= 1'b1;
                            r_rx_start  <= r_first;
                            r_first     <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign bus.spi_miso  = r_miso;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_strobe = r_rx_strobe;
    assign bus.rx_start  = r_rx_start;
`ifdef MCU_SPI_FRAME_ERR_EN
    assign frame_err_cnt = r_frame_err_cnt;
`endif

endmodule
